// File: rtl/if_rd_arbiter_pkg.sv
// ============================================================================
// Module : if_pkg
// Shared interface codes, per-code read sizes and arbiter FSM encoding.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package if_pkg;

  localparam logic [3:0] IFCODE_CFG    = 4'd1;
  localparam logic [3:0] IFCODE_ACT    = 4'd2;
  localparam logic [3:0] IFCODE_FLGACT = 4'd3;
  localparam logic [3:0] IFCODE_WEI    = 4'd4;
  localparam logic [3:0] IFCODE_FLGWEI = 4'd5;

  // Beats moved by the FIFO controller for each interface code
  localparam int RD_SIZE_CFG    = 2;
  localparam int RD_SIZE_ACT    = 4;
  localparam int RD_SIZE_FLGACT = 3;
  localparam int RD_SIZE_WEI    = 5;
  localparam int RD_SIZE_FLGWEI = 3;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CFG      = 2'd1,
    ST_XFER     = 2'd2,
    ST_WAIT_RDY = 2'd3
  } arb_state_e;

  function automatic int rd_size(input logic [3:0] code);
    case (code)
      IFCODE_CFG:    return RD_SIZE_CFG;
      IFCODE_ACT:    return RD_SIZE_ACT;
      IFCODE_FLGACT: return RD_SIZE_FLGACT;
      IFCODE_WEI:    return RD_SIZE_WEI;
      IFCODE_FLGWEI: return RD_SIZE_FLGWEI;
      default:       return 0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/if_rd_arbiter_if.sv
// ============================================================================
// Module : if_rd_arbiter_if
// Config and read handshake between the arbiter and the FIFO read controller.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface if_rd_arbiter_if #(
  parameter int SPI_WIDTH = 32,
  parameter int CODE_W    = 4
);
  logic                 config_ready;
  logic                 config_paulse;
  logic [CODE_W-1:0]    config_data;
  logic                 Reset_WEI_IF_CFG;
  logic                 rd_req;
  logic                 rd_valid;
  logic [SPI_WIDTH-1:0] rd_data;
  logic                 rd_done;

  modport master (
    input  config_ready, rd_valid, rd_data, rd_done,
    output config_paulse, config_data, Reset_WEI_IF_CFG, rd_req
  );

  modport slave (
    output config_ready, rd_valid, rd_data, rd_done,
    input  config_paulse, config_data, Reset_WEI_IF_CFG, rd_req
  );
endinterface

`default_nettype wire

// File: rtl/if_rd_arbiter_rr.sv
// ============================================================================
// Module : rr_arbiter_onehot
// Picks the first asserted request at or after ptr, wrapping circularly.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module rr_arbiter_onehot #(
  parameter int NUM_REQ = 5,
  parameter int IDX_W   = 3
) (
  input  wire logic [NUM_REQ-1:0] req,
  input  wire logic [IDX_W-1:0]   ptr,
  output logic      [NUM_REQ-1:0] gnt,
  output logic      [IDX_W-1:0]   idx,
  output logic                    any
);

  logic [IDX_W:0]   w_pos;
  logic [IDX_W-1:0] w_j;

  // One extra bit keeps ptr+k from overflowing before the wrap subtract
  always_comb begin
    gnt   = '0;
    idx   = '0;
    any   = 1'b0;
    w_pos = '0;
    w_j   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_pos = {1'b0, ptr} + (IDX_W+1)'(k);
      if (w_pos >= (IDX_W+1)'(NUM_REQ))
        w_pos = w_pos - (IDX_W+1)'(NUM_REQ);
      w_j = w_pos[IDX_W-1:0];
      if (!any && req[w_j]) begin
        any      = 1'b1;
        gnt[w_j] = 1'b1;
        idx      = w_j;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/if_rd_arbiter.sv
// ============================================================================
// Module : if_rd_arbiter
// Round-robin share of the FIFO read port among the on-chip loaders.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module if_rd_arbiter
  import if_pkg::*;
#(
  parameter int                         NUM_REQ   = 5,
  parameter int                         SPI_WIDTH = 32,
  parameter int                         CODE_W    = 4,
  parameter logic [NUM_REQ*CODE_W-1:0]  REQ_CODES = {IFCODE_FLGWEI, IFCODE_WEI,
                                                     IFCODE_FLGACT, IFCODE_ACT,
                                                     IFCODE_CFG},
  parameter int                         WDOG_W    = 16
) (
  input  wire logic                 clk_chip,
  input  wire logic                 reset_n_chip,
  input  wire logic [NUM_REQ-1:0]   req,
  input  wire logic [NUM_REQ-1:0]   req_reset_wei,
  input  wire logic [NUM_REQ-1:0]   req_ready,
  output logic      [NUM_REQ-1:0]   gnt,
  output logic      [NUM_REQ-1:0]   dat_valid,
  output logic      [SPI_WIDTH-1:0] dat_data,
  output logic      [NUM_REQ-1:0]   done,
  output logic                      timeout_err,
  input  wire logic                 err_clr,
  if_rd_arbiter_if.master           fifo
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_e         r_state;
  arb_state_e         w_state_nxt;
  logic [IDX_W-1:0]   r_rr_ptr;
  logic [NUM_REQ-1:0] r_gnt;
  logic [IDX_W-1:0]   r_idx;
  logic [CODE_W-1:0]  r_code;
  logic               r_wei;
  logic [WDOG_W-1:0]  r_wdog;
  logic               r_timeout;

  logic [NUM_REQ-1:0] w_arb_gnt;
  logic [IDX_W-1:0]   w_arb_idx;
  logic               w_arb_any;
  logic               w_grant_load;
  logic               w_xfer_end;
  logic               w_cfg_pulse;
  logic               w_rd_req;
  logic [NUM_REQ-1:0] w_dat_valid;
  logic [SPI_WIDTH-1:0] w_dat_data;
  logic [NUM_REQ-1:0] w_done;
  logic [WDOG_W-1:0]  w_wdog_inc;
  logic [WDOG_W-1:0]  w_wdog_nxt;
  logic               w_expire;

  rr_arbiter_onehot #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req (req),
    .ptr (r_rr_ptr),
    .gnt (w_arb_gnt),
    .idx (w_arb_idx),
    .any (w_arb_any)
  );

  always_ff @(posedge clk_chip or negedge reset_n_chip) begin
    if (!reset_n_chip) r_state <= ST_IDLE;
    else               r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_grant_load = 1'b0;
    w_xfer_end   = 1'b0;
    w_cfg_pulse  = 1'b0;
    w_rd_req     = 1'b0;
    w_dat_valid  = '0;
    w_dat_data   = '0;
    w_done       = '0;
    case (r_state)
      ST_IDLE: begin
        if (fifo.config_ready && w_arb_any) begin
          w_grant_load = 1'b1;
          w_state_nxt  = ST_CFG;
        end
      end
      ST_CFG: begin
        w_cfg_pulse = 1'b1;
        w_state_nxt = ST_XFER;
      end
      ST_XFER: begin
        w_rd_req    = req_ready[r_idx];
        w_dat_valid = r_gnt & {NUM_REQ{fifo.rd_valid}};
        w_dat_data  = fifo.rd_data;
        if (fifo.rd_done) begin
          w_done      = r_gnt;
          w_xfer_end  = 1'b1;
          w_state_nxt = ST_WAIT_RDY;
        end
      end
      ST_WAIT_RDY: begin
        // Hold off regrant until the FIFO controller has left its reset state
        if (fifo.config_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Watchdog saturates at all-ones; expiry is flagged on the edge it gets there
  always_comb begin
    w_wdog_inc = (r_wdog == '1) ? r_wdog : r_wdog + WDOG_W'(1);
    w_wdog_nxt = '0;
    w_expire   = 1'b0;
    if (r_state == ST_XFER && !fifo.rd_valid) begin
      w_wdog_nxt = w_wdog_inc;
      w_expire   = (w_wdog_inc == '1);
    end
  end

  always_ff @(posedge clk_chip or negedge reset_n_chip) begin
    if (!reset_n_chip) begin
      r_rr_ptr  <= '0;
      r_gnt     <= '0;
      r_idx     <= '0;
      r_code    <= '0;
      r_wei     <= 1'b0;
      r_wdog    <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (w_grant_load) begin
        r_gnt  <= w_arb_gnt;
        r_idx  <= w_arb_idx;
        r_code <= REQ_CODES[w_arb_idx*CODE_W +: CODE_W];
        r_wei  <= req_reset_wei[w_arb_idx];
      end
      if (w_xfer_end) begin
        r_gnt    <= '0;
        r_rr_ptr <= (r_idx == IDX_W'(NUM_REQ-1)) ? '0 : r_idx + IDX_W'(1);
      end
      r_wdog <= w_wdog_nxt;
      if (w_expire)     r_timeout <= 1'b1;
      else if (err_clr) r_timeout <= 1'b0;
    end
  end

  assign gnt                   = r_gnt;
  assign dat_valid             = w_dat_valid;
  assign dat_data              = w_dat_data;
  assign done                  = w_done;
  assign timeout_err           = r_timeout;
  assign fifo.config_paulse    = w_cfg_pulse;
  assign fifo.config_data      = r_code;
  assign fifo.Reset_WEI_IF_CFG = r_wei;
  assign fifo.rd_req           = w_rd_req;

endmodule

`default_nettype wire

// File: tb/tb_if_rd_arbiter.sv
// ============================================================================
// Module : tb_if_rd_arbiter
// Directed bench for if_rd_arbiter: vector table plus multi-cycle sequences.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_if_rd_arbiter;
  import if_pkg::*;

  logic        clk_chip = 1'b0;
  logic        reset_n_chip = 1'b0;
  logic [4:0]  req = '0;
  logic [4:0]  req_reset_wei = '0;
  logic [4:0]  req_ready = '0;
  logic [4:0]  gnt;
  logic [4:0]  dat_valid;
  logic [31:0] dat_data;
  logic [4:0]  done;
  logic        timeout_err;
  logic        err_clr = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0] codes [5];
  int         sz    [5];

  if_rd_arbiter_if #(.SPI_WIDTH(32), .CODE_W(4)) fifo_if ();

  if_rd_arbiter #(
    .NUM_REQ   (5),
    .SPI_WIDTH (32),
    .CODE_W    (4),
    .WDOG_W    (4)
  ) dut (
    .clk_chip      (clk_chip),
    .reset_n_chip  (reset_n_chip),
    .req           (req),
    .req_reset_wei (req_reset_wei),
    .req_ready     (req_ready),
    .gnt           (gnt),
    .dat_valid     (dat_valid),
    .dat_data      (dat_data),
    .done          (done),
    .timeout_err   (timeout_err),
    .err_clr       (err_clr),
    .fifo          (fifo_if)
  );

  always #5 clk_chip = ~clk_chip;

  typedef struct {
    logic [4:0]  req;
    logic [4:0]  rdy;
    logic        cfg_rdy;
    logic        vld;
    logic [31:0] data;
    logic        rdone;
    logic [4:0]  e_gnt;
    logic [4:0]  e_dv;
    logic        e_rdreq;
    logic [4:0]  e_done;
    logic        e_cp;
    logic [3:0]  e_cd;
    logic [31:0] e_data;
  } vec_t;

  vec_t tbl [10];

  task automatic tick();
    @(posedge clk_chip);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset_n_chip = 1'b0;
    req = '0; req_reset_wei = '0; req_ready = '0; err_clr = 1'b0;
    fifo_if.config_ready = 1'b0; fifo_if.rd_valid = 1'b0;
    fifo_if.rd_data = '0; fifo_if.rd_done = 1'b0;
    tick();
    tick();
    reset_n_chip = 1'b1;
    tick();
  endtask

  // One whole transfer from IDLE: expects grant idx, drives RD_SIZE beats
  task automatic do_xfer(input int idx, input logic exp_wei);
    logic [4:0] mask;
    int         beats;
    bit         found;
    mask  = 5'd1 << idx;
    found = 1'b0;
    for (int k = 0; k < 8 && !found; k++) begin
      @(negedge clk_chip);
      if (fifo_if.config_paulse) found = 1'b1;
      else tick();
    end
    if (!found) begin
      n_checks++;
      n_fail++;
      $display("FAIL cfg_wait: got no config pulse required pulse within 8 cycles (idx %0d)", idx);
      return;
    end
    chk("cfg_gnt", gnt, mask);
    chk("cfg_code", fifo_if.config_data, codes[idx]);
    chk("cfg_wei", fifo_if.Reset_WEI_IF_CFG, exp_wei);
    tick();
    fifo_if.config_ready = 1'b0;
    req_reset_wei = '0;
    beats = 0;
    for (int b = 0; b < sz[idx]; b++) begin
      fifo_if.rd_valid = 1'b1;
      fifo_if.rd_data  = 32'hC0DE_0000 + 32'(idx << 8) + 32'(b);
      req_ready        = (b % 2 == 0) ? 5'h1f : ~mask;
      @(negedge clk_chip);
      chk("beat_rd_req", fifo_if.rd_req, (b % 2 == 0));
      chk("beat_data", dat_data, 32'hC0DE_0000 + 32'(idx << 8) + 32'(b));
      if (dat_valid == mask) beats++;
      tick();
    end
    fifo_if.rd_valid = 1'b0;
    req_ready = 5'h1f;
    fifo_if.rd_done = 1'b1;
    @(negedge clk_chip);
    chk("beat_count", beats, sz[idx]);
    chk("done_pulse", done, mask);
    chk("wei_hold", fifo_if.Reset_WEI_IF_CFG, exp_wei);
    tick();
    fifo_if.rd_done = 1'b0;
    for (int w = 0; w < 2; w++) begin
      @(negedge clk_chip);
      chk("wait_gnt", gnt, 5'd0);
      chk("wait_cp", fifo_if.config_paulse, 1'b0);
      tick();
    end
    fifo_if.config_ready = 1'b1;
    tick();
  endtask

  initial begin
    int order [6];
    codes = '{IFCODE_CFG, IFCODE_ACT, IFCODE_FLGACT, IFCODE_WEI, IFCODE_FLGWEI};
    sz    = '{RD_SIZE_CFG, RD_SIZE_ACT, RD_SIZE_FLGACT, RD_SIZE_WEI, RD_SIZE_FLGWEI};
    order = '{0, 1, 2, 3, 4, 0};

    // req, rdy, cfg_rdy, vld, data, rdone | gnt, dv, rd_req, done, cp, cd, data
    tbl[0] = '{5'b00010, 5'b00010, 1, 0, 32'h0,        0, 5'b00000, 5'b00000, 0, 5'b00000, 0, 4'd0, 32'h0};
    tbl[1] = '{5'b00010, 5'b00010, 0, 0, 32'h0,        0, 5'b00010, 5'b00000, 0, 5'b00000, 1, 4'd2, 32'h0};
    tbl[2] = '{5'b00010, 5'b00010, 0, 1, 32'hA0,       0, 5'b00010, 5'b00010, 1, 5'b00000, 0, 4'd2, 32'hA0};
    tbl[3] = '{5'b00010, 5'b00000, 0, 1, 32'hA1,       0, 5'b00010, 5'b00010, 0, 5'b00000, 0, 4'd2, 32'hA1};
    tbl[4] = '{5'b00010, 5'b00010, 0, 1, 32'hA2,       0, 5'b00010, 5'b00010, 1, 5'b00000, 0, 4'd2, 32'hA2};
    tbl[5] = '{5'b00010, 5'b00000, 0, 1, 32'hA3,       0, 5'b00010, 5'b00010, 0, 5'b00000, 0, 4'd2, 32'hA3};
    tbl[6] = '{5'b00010, 5'b00010, 0, 0, 32'h0,        1, 5'b00010, 5'b00000, 1, 5'b00010, 0, 4'd2, 32'h0};
    tbl[7] = '{5'b00010, 5'b00010, 0, 1, 32'hDEADBEEF, 0, 5'b00000, 5'b00000, 0, 5'b00000, 0, 4'd2, 32'h0};
    tbl[8] = '{5'b00010, 5'b00010, 1, 0, 32'h0,        0, 5'b00000, 5'b00000, 0, 5'b00000, 0, 4'd2, 32'h0};
    tbl[9] = '{5'b00000, 5'b00010, 1, 0, 32'h0,        1, 5'b00000, 5'b00000, 0, 5'b00000, 0, 4'd2, 32'h0};

    do_reset();
    @(negedge clk_chip);
    chk("rst_gnt", gnt, 5'd0);
    chk("rst_dv", dat_valid, 5'd0);
    chk("rst_done", done, 5'd0);
    chk("rst_rd_req", fifo_if.rd_req, 1'b0);
    chk("rst_cp", fifo_if.config_paulse, 1'b0);
    chk("rst_cd", fifo_if.config_data, 4'd0);
    chk("rst_wei", fifo_if.Reset_WEI_IF_CFG, 1'b0);
    chk("rst_timeout", timeout_err, 1'b0);
    tick();

    // Single ACT transfer, cycle by cycle
    for (int i = 0; i < 10; i++) begin
      req                  = tbl[i].req;
      req_ready            = tbl[i].rdy;
      fifo_if.config_ready = tbl[i].cfg_rdy;
      fifo_if.rd_valid     = tbl[i].vld;
      fifo_if.rd_data      = tbl[i].data;
      fifo_if.rd_done      = tbl[i].rdone;
      @(negedge clk_chip);
      chk($sformatf("v%0d_gnt", i), gnt, tbl[i].e_gnt);
      chk($sformatf("v%0d_dv", i), dat_valid, tbl[i].e_dv);
      chk($sformatf("v%0d_rd_req", i), fifo_if.rd_req, tbl[i].e_rdreq);
      chk($sformatf("v%0d_done", i), done, tbl[i].e_done);
      chk($sformatf("v%0d_cp", i), fifo_if.config_paulse, tbl[i].e_cp);
      chk($sformatf("v%0d_cd", i), fifo_if.config_data, tbl[i].e_cd);
      chk($sformatf("v%0d_data", i), dat_data, tbl[i].e_data);
      tick();
    end

    // Round robin with every requester asserted
    do_reset();
    req = 5'h1f; req_ready = 5'h1f; fifo_if.config_ready = 1'b1;
    for (int i = 0; i < 6; i++) do_xfer(order[i], 1'b0);

    // Reset_WEI sampled at grant and held after the request flag drops
    do_reset();
    req = 5'b01000; req_reset_wei = 5'b01000; req_ready = 5'h1f;
    fifo_if.config_ready = 1'b1;
    do_xfer(3, 1'b1);

    // Watchdog expiry, set-wins against err_clr, sticky, then clear
    do_reset();
    req = 5'b00001; req_ready = 5'h1f; fifo_if.config_ready = 1'b1;
    tick();
    @(negedge clk_chip);
    chk("wd_cfg", fifo_if.config_paulse, 1'b1);
    tick();
    fifo_if.config_ready = 1'b0;
    repeat (14) tick();
    @(negedge clk_chip);
    chk("wd_14", timeout_err, 1'b0);
    tick();
    @(negedge clk_chip);
    chk("wd_15", timeout_err, 1'b1);
    err_clr = 1'b1;
    tick();
    @(negedge clk_chip);
    chk("wd_set_wins", timeout_err, 1'b1);
    err_clr = 1'b0;
    tick();
    fifo_if.rd_valid = 1'b1;
    tick();
    tick();
    fifo_if.rd_valid = 1'b0;
    fifo_if.rd_done  = 1'b1;
    req = '0;
    @(negedge clk_chip);
    chk("wd_done", done, 5'b00001);
    tick();
    fifo_if.rd_done = 1'b0;
    fifo_if.config_ready = 1'b1;
    tick();
    @(negedge clk_chip);
    chk("wd_sticky", timeout_err, 1'b1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    @(negedge clk_chip);
    chk("wd_clr", timeout_err, 1'b0);
    tick();

    // Asynchronous reset in the middle of a transfer
    do_reset();
    req = 5'b00100; req_ready = 5'h1f; fifo_if.config_ready = 1'b1;
    do_xfer(2, 1'b0);
    req = 5'h1f;
    tick();
    @(negedge clk_chip);
    chk("mid_gnt", gnt, 5'b01000);
    tick();
    fifo_if.rd_valid = 1'b1;
    @(negedge clk_chip);
    chk("mid_rd_req", fifo_if.rd_req, 1'b1);
    fifo_if.rd_done = 1'b1;
    reset_n_chip = 1'b0;
    #1;
    chk("arst_gnt", gnt, 5'd0);
    chk("arst_rd_req", fifo_if.rd_req, 1'b0);
    chk("arst_done", done, 5'd0);
    chk("arst_dv", dat_valid, 5'd0);
    tick();
    reset_n_chip = 1'b1;
    fifo_if.rd_done = 1'b0;
    fifo_if.rd_valid = 1'b0;
    tick();
    @(negedge clk_chip);
    chk("arst_ptr0", gnt, 5'b00001);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
